// File: rtl/cache_types.sv
// Shared types for the I/D cache arbiter: line type, FSM state encoding and
// the tie-break helper used when both caches request at once.
package cache_types;

    localparam int LINE_WIDTH = 256;

    typedef logic [LINE_WIDTH-1:0] line_t;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t I_BUSY = 2'd1;
    localparam arb_state_t D_BUSY = 2'd2;
    localparam arb_state_t DONE   = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // On a conflict the side that did not win last time goes next.
    function automatic logic pick_d(input logic i_req, input logic d_req,
                                    input logic last_grant);
        if (i_req && d_req) return (last_grant == GRANT_I);
        return d_req;
    endfunction

endpackage

// File: rtl/cache_arbiter_arb_req_latch.sv
// Holds the granted request (address, write line, op) for the whole memory
// transaction so cache-side changes cannot disturb the memory interface.
module arb_req_latch #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] nxt_addr,
    input  logic [LINE_W-1:0] nxt_wdata,
    input  logic              nxt_write,
    output logic [ADDR_W-1:0] addr,
    output logic [LINE_W-1:0] wdata,
    output logic              write
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            wdata <= '0;
            write <= 1'b0;
        end else if (load) begin
            addr  <= nxt_addr;
            wdata <= nxt_wdata;
            write <= nxt_write;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Merges I-cache fills and D-cache fills/write-backs onto one memory line
// port: one transaction at a time, alternating on conflicts.
module cache_arbiter
    import cache_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = LINE_WIDTH
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state, state_nxt;
    logic              last_grant;
    logic              i_req, d_req;
    logic              grant, grant_d;
    logic [ADDR_W-1:0] nxt_addr, lat_addr;
    logic [LINE_W-1:0] nxt_wdata, lat_wdata;
    logic              nxt_write, lat_write;

    assign i_req   = icache_read;
    assign d_req   = dcache_read | dcache_write;
    assign grant   = (state == IDLE) && (i_req || d_req);
    assign grant_d = pick_d(i_req, d_req, last_grant);

    // Read+write together from the D-cache is treated as a write-back.
    assign nxt_addr  = grant_d ? dcache_address : icache_address;
    assign nxt_wdata = grant_d ? dcache_wdata : '0;
    assign nxt_write = grant_d & dcache_write;

    arb_req_latch #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_req_latch (
        .clk       (clk),
        .rst       (rst),
        .load      (grant),
        .nxt_addr  (nxt_addr),
        .nxt_wdata (nxt_wdata),
        .nxt_write (nxt_write),
        .addr      (lat_addr),
        .wdata     (lat_wdata),
        .write     (lat_write)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = grant_d ? D_BUSY : I_BUSY;
            I_BUSY:  if (pmem_resp) state_nxt = DONE;
            D_BUSY:  if (pmem_resp) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state <= state_nxt;
            if (grant) last_grant <= grant_d;
        end
    end

    // Memory side is decoded from registered state only.
    assign pmem_read    = (state == I_BUSY) || ((state == D_BUSY) && !lat_write);
    assign pmem_write   = (state == D_BUSY) && lat_write;
    assign pmem_address = lat_addr;
    assign pmem_wdata   = lat_wdata;

    assign icache_resp  = (state == I_BUSY) && pmem_resp;
    assign dcache_resp  = (state == D_BUSY) && pmem_resp;
    assign icache_rdata = icache_resp ? pmem_rdata : '0;
    assign dcache_rdata = dcache_resp ? pmem_rdata : '0;

endmodule
